// File: rtl/core_pkg.sv
// Shared core types: register index, data word, rd source and load size encodings.
package core_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_index_t;

    typedef enum logic [1:0] {
        RD_FROM_ALU_RESULT  = 2'b00,
        RD_FROM_NEXT_SEQ_PC = 2'b01,
        RD_FROM_CSR_RDATA   = 2'b10,
        RD_FROM_MEM_LOAD    = 2'b11
    } rd_src_e;

    // Encoding 2'b11 is left unnamed; load formatting treats it as a full word.
    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALFWORD = 2'b01,
        SIZE_WORD     = 2'b10
    } mem_size_e;

    typedef enum logic {
        W_IDLE      = 1'b0,
        W_WAIT_LOAD = 1'b1
    } w_state_e;

endpackage

// File: rtl/letc_core_stage_w_if.sv
// Bundle of the M->W packet handshake and the load response channel.
interface letc_core_stage_w_if;
    import core_pkg::*;

    logic       m_valid;
    logic       m_ready;
    logic       rd_we;
    reg_index_t rd_idx;
    rd_src_e    rd_src;
    word_t      alu_result;
    word_t      next_seq_pc;
    word_t      csr_rdata;
    mem_size_e  mem_size;
    logic       mem_unsigned;
    logic [1:0] addr_lo;
    logic       ld_rvalid;
    word_t      ld_rdata;

    modport master (
        output m_valid, rd_we, rd_idx, rd_src, alu_result, next_seq_pc, csr_rdata,
               mem_size, mem_unsigned, addr_lo, ld_rvalid, ld_rdata,
        input  m_ready
    );

    modport slave (
        input  m_valid, rd_we, rd_idx, rd_src, alu_result, next_seq_pc, csr_rdata,
               mem_size, mem_unsigned, addr_lo, ld_rvalid, ld_rdata,
        output m_ready
    );

endinterface

// File: rtl/letc_core_load_fmt.sv
// Combinational load formatter: picks the addressed byte/halfword and extends it.
module letc_core_load_fmt
    import core_pkg::*;
(
    input  word_t      rdata,
    input  mem_size_e  size,
    input  logic       mem_unsigned,
    input  logic [1:0] addr_lo,
    output word_t      result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        sel_byte = rdata[{addr_lo, 3'b000} +: 8];
        sel_half = rdata[{addr_lo[1], 4'b0000} +: 16];
        result   = rdata;
        case (size)
            SIZE_BYTE:     result = {{24{~mem_unsigned & sel_byte[7]}}, sel_byte};
            SIZE_HALFWORD: result = {{16{~mem_unsigned & sel_half[15]}}, sel_half};
            default:       result = rdata;
        endcase
    end

endmodule

// File: rtl/letc_core_stage_w.sv
// Writeback stage: retires M-stage packets into the register file, stalling on loads.
module letc_core_stage_w
    import core_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_m_valid,
    output logic        o_m_ready,
    input  logic        i_m_rd_we,
    input  reg_index_t  i_m_rd_idx,
    input  rd_src_e     i_m_rd_src,
    input  word_t       i_m_alu_result,
    input  word_t       i_m_next_seq_pc,
    input  word_t       i_m_csr_rdata,
    input  mem_size_e   i_m_mem_size,
    input  logic        i_m_mem_unsigned,
    input  logic [1:0]  i_m_addr_lo,

    input  logic        i_ld_rvalid,
    input  word_t       i_ld_rdata,

    output logic        o_rf_we,
    output reg_index_t  o_rf_idx,
    output word_t       o_rf_wdata,
    output logic        o_retire,
    output logic [63:0] o_instret
);

    w_state_e   state_q, state_d;

    logic       ld_rd_we_q;
    reg_index_t ld_rd_idx_q;
    mem_size_e  ld_size_q;
    logic       ld_unsigned_q;
    logic [1:0] ld_addr_lo_q;

    logic       accept;
    logic       accept_load;
    logic       retire_d;
    logic       rd_we_d;
    reg_index_t rf_idx_d;
    word_t      rf_wdata_d;
    word_t      ld_formatted;

    letc_core_load_fmt u_load_fmt (
        .rdata        (i_ld_rdata),
        .size         (ld_size_q),
        .mem_unsigned (ld_unsigned_q),
        .addr_lo      (ld_addr_lo_q),
        .result       (ld_formatted)
    );

    assign accept      = i_m_valid && (state_q == W_IDLE);
    assign accept_load = accept && (i_m_rd_src == RD_FROM_MEM_LOAD);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= W_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            W_IDLE:      if (accept_load) state_d = W_WAIT_LOAD;
            W_WAIT_LOAD: if (i_ld_rvalid) state_d = W_IDLE;
            default:     state_d = W_IDLE;
        endcase
    end

    // Retire decision and write payload for the coming edge; i_ld_rvalid only matters while waiting.
    always_comb begin
        o_m_ready  = (state_q == W_IDLE);
        retire_d   = 1'b0;
        rd_we_d    = 1'b0;
        rf_idx_d   = o_rf_idx;
        rf_wdata_d = o_rf_wdata;
        case (state_q)
            W_IDLE: begin
                if (accept && !accept_load) begin
                    retire_d = 1'b1;
                    rd_we_d  = i_m_rd_we;
                    rf_idx_d = i_m_rd_idx;
                    case (i_m_rd_src)
                        RD_FROM_NEXT_SEQ_PC: rf_wdata_d = i_m_next_seq_pc;
                        RD_FROM_CSR_RDATA:   rf_wdata_d = i_m_csr_rdata;
                        default:             rf_wdata_d = i_m_alu_result;
                    endcase
                end
            end
            W_WAIT_LOAD: begin
                if (i_ld_rvalid) begin
                    retire_d   = 1'b1;
                    rd_we_d    = ld_rd_we_q;
                    rf_idx_d   = ld_rd_idx_q;
                    rf_wdata_d = ld_formatted;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the load context is only read in W_WAIT_LOAD, which reset cannot reach, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (accept_load) begin
            ld_rd_we_q    <= i_m_rd_we;
            ld_rd_idx_q   <= i_m_rd_idx;
            ld_size_q     <= i_m_mem_size;
            ld_unsigned_q <= i_m_mem_unsigned;
            ld_addr_lo_q  <= i_m_addr_lo;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_retire   <= 1'b0;
            o_rf_we    <= 1'b0;
            o_rf_idx   <= '0;
            o_rf_wdata <= '0;
            o_instret  <= '0;
        end else begin
            o_retire <= retire_d;
            o_rf_we  <= rd_we_d && (rf_idx_d != '0);
            if (retire_d) begin
                o_rf_idx   <= rf_idx_d;
                o_rf_wdata <= rf_wdata_d;
                o_instret  <= o_instret + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_letc_core_stage_w.sv
// Self-checking bench for letc_core_stage_w: directed cases plus random traffic vs a reference model.
module tb_letc_core_stage_w;
    import core_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_rf_we;
    reg_index_t  o_rf_idx;
    word_t       o_rf_wdata;
    logic        o_retire;
    logic [63:0] o_instret;

    int n_checks = 0;
    int n_fail   = 0;
    int ready_low;

    // Reference model state
    bit          m_wait;
    logic        m_we_l;
    reg_index_t  m_idx_l;
    logic [1:0]  m_sz_l;
    logic        m_u_l;
    logic [1:0]  m_a_l;
    logic        exp_retire, exp_we;
    reg_index_t  exp_idx;
    word_t       exp_wdata;
    logic [63:0] exp_instret;

    always #5 i_clk = ~i_clk;

    letc_core_stage_w_if m_if ();

    letc_core_stage_w dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_m_valid        (m_if.m_valid),
        .o_m_ready        (m_if.m_ready),
        .i_m_rd_we        (m_if.rd_we),
        .i_m_rd_idx       (m_if.rd_idx),
        .i_m_rd_src       (m_if.rd_src),
        .i_m_alu_result   (m_if.alu_result),
        .i_m_next_seq_pc  (m_if.next_seq_pc),
        .i_m_csr_rdata    (m_if.csr_rdata),
        .i_m_mem_size     (m_if.mem_size),
        .i_m_mem_unsigned (m_if.mem_unsigned),
        .i_m_addr_lo      (m_if.addr_lo),
        .i_ld_rvalid      (m_if.ld_rvalid),
        .i_ld_rdata       (m_if.ld_rdata),
        .o_rf_we          (o_rf_we),
        .o_rf_idx         (o_rf_idx),
        .o_rf_wdata       (o_rf_wdata),
        .o_retire         (o_retire),
        .o_instret        (o_instret)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Load result from the arithmetic meaning of the load, not the RTL's slicing.
    function automatic word_t fmt_ref(word_t d, logic [1:0] sz, logic u, logic [1:0] a);
        word_t v;
        if (sz == 2'b00) begin
            v = (d >> (8 * a)) & 32'h0000_00FF;
            if (!u && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (d >> (16 * a[1])) & 32'h0000_FFFF;
            if (!u && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    task automatic clear_inputs();
        m_if.m_valid      = 1'b0;
        m_if.rd_we        = 1'b0;
        m_if.rd_idx       = '0;
        m_if.rd_src       = RD_FROM_ALU_RESULT;
        m_if.alu_result   = '0;
        m_if.next_seq_pc  = '0;
        m_if.csr_rdata    = '0;
        m_if.mem_size     = SIZE_WORD;
        m_if.mem_unsigned = 1'b0;
        m_if.addr_lo      = '0;
        m_if.ld_rvalid    = 1'b0;
        m_if.ld_rdata     = '0;
    endtask

    task automatic model_reset();
        m_wait      = 1'b0;
        exp_retire  = 1'b0;
        exp_we      = 1'b0;
        exp_idx     = '0;
        exp_wdata   = '0;
        exp_instret = '0;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_retire"},  {63'd0, o_retire},   {63'd0, exp_retire});
        check({pfx, "_rf_we"},   {63'd0, o_rf_we},    {63'd0, exp_we});
        check({pfx, "_rf_idx"},  {59'd0, o_rf_idx},   {59'd0, exp_idx});
        check({pfx, "_wdata"},   {32'd0, o_rf_wdata}, {32'd0, exp_wdata});
        check({pfx, "_instret"}, o_instret,           exp_instret);
    endtask

    // One clock: check ready, advance the model with the current inputs, then check outputs.
    task automatic tick();
        word_t sel;
        check("m_ready", {63'd0, m_if.m_ready}, {63'd0, !m_wait});
        if (!m_if.m_ready) ready_low++;
        exp_retire = 1'b0;
        exp_we     = 1'b0;
        if (!m_wait) begin
            if (m_if.m_valid) begin
                if (m_if.rd_src == RD_FROM_MEM_LOAD) begin
                    m_wait  = 1'b1;
                    m_we_l  = m_if.rd_we;
                    m_idx_l = m_if.rd_idx;
                    m_sz_l  = m_if.mem_size;
                    m_u_l   = m_if.mem_unsigned;
                    m_a_l   = m_if.addr_lo;
                end else begin
                    if (m_if.rd_src == RD_FROM_NEXT_SEQ_PC)    sel = m_if.next_seq_pc;
                    else if (m_if.rd_src == RD_FROM_CSR_RDATA) sel = m_if.csr_rdata;
                    else                                       sel = m_if.alu_result;
                    exp_retire = 1'b1;
                    exp_idx    = m_if.rd_idx;
                    exp_wdata  = sel;
                    exp_we     = m_if.rd_we && (m_if.rd_idx != 0);
                end
            end
        end else if (m_if.ld_rvalid) begin
            m_wait     = 1'b0;
            exp_retire = 1'b1;
            exp_idx    = m_idx_l;
            exp_wdata  = fmt_ref(m_if.ld_rdata, m_sz_l, m_u_l, m_a_l);
            exp_we     = m_we_l && (m_idx_l != 0);
        end
        if (exp_retire) exp_instret = exp_instret + 64'd1;
        @(posedge i_clk);
        @(negedge i_clk);
        check_outputs("cyc");
    endtask

    task automatic do_reset();
        clear_inputs();
        i_rst = 1'b1;
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        check("rst_m_ready", {63'd0, m_if.m_ready}, 64'd1);
        check_outputs("rst");
        i_rst = 1'b0;
    endtask

    task automatic alu_packet(input reg_index_t idx, input logic we, input word_t val);
        m_if.m_valid    = 1'b1;
        m_if.rd_we      = we;
        m_if.rd_idx     = idx;
        m_if.rd_src     = RD_FROM_ALU_RESULT;
        m_if.alu_result = val;
    endtask

    task automatic load_packet(input reg_index_t idx, input mem_size_e sz, input logic u,
                               input logic [1:0] a);
        m_if.m_valid      = 1'b1;
        m_if.rd_we        = 1'b1;
        m_if.rd_idx       = idx;
        m_if.rd_src       = RD_FROM_MEM_LOAD;
        m_if.mem_size     = sz;
        m_if.mem_unsigned = u;
        m_if.addr_lo      = a;
    endtask

    initial begin
        i_rst = 1'b1;
        clear_inputs();
        model_reset();
        @(negedge i_clk);
        do_reset();

        // Back-to-back ALU packets
        for (int i = 0; i < 3; i++) begin
            alu_packet(reg_index_t'(5 + i), 1'b1, word_t'(32'h11 * (i + 1)));
            tick();
        end
        clear_inputs();
        tick();
        check("b2b_instret", o_instret, 64'd3);

        // Signed byte load with a delayed response
        load_packet(5'd9, SIZE_BYTE, 1'b0, 2'd2);
        m_if.ld_rvalid = 1'b1;   // ignored in the accept cycle
        m_if.ld_rdata  = 32'hDEAD_BEEF;
        tick();
        clear_inputs();
        ready_low = 0;
        for (int i = 0; i < 4; i++) tick();
        m_if.ld_rvalid = 1'b1;
        m_if.ld_rdata  = 32'h1280_3456;
        tick();
        clear_inputs();
        check("sbyte_ready_low", 64'(ready_low), 64'd5);
        check("sbyte_wdata", {32'd0, o_rf_wdata}, 64'hFFFF_FF80);

        // Unsigned halfword load at addr_lo=3
        load_packet(5'd10, SIZE_HALFWORD, 1'b1, 2'd3);
        tick();
        clear_inputs();
        m_if.ld_rvalid = 1'b1;
        m_if.ld_rdata  = 32'hBEEF_1234;
        tick();
        clear_inputs();
        check("uhalf_wdata", {32'd0, o_rf_wdata}, 64'h0000_BEEF);

        // Write to x0 retires without a register write
        alu_packet(5'd0, 1'b1, 32'hCAFE_F00D);
        tick();
        clear_inputs();
        check("x0_retire", {63'd0, o_retire}, 64'd1);
        check("x0_rf_we", {63'd0, o_rf_we}, 64'd0);
        check("x0_instret", o_instret, 64'd6);

        // Reset while waiting on a load discards it
        load_packet(5'd12, SIZE_WORD, 1'b0, 2'd0);
        tick();
        clear_inputs();
        tick();
        #2 i_rst = 1'b1;
        model_reset();
        m_if.ld_rvalid = 1'b1;
        m_if.ld_rdata  = 32'h1234_5678;
        @(negedge i_clk);
        check_outputs("rst_wait");
        check("rst_wait_ready", {63'd0, m_if.m_ready}, 64'd1);
        i_rst = 1'b0;
        tick();
        clear_inputs();
        tick();
        check("rst_wait_instret", o_instret, 64'd0);

        // Instret wrap
        force dut.o_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.o_instret;
        exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        alu_packet(5'd3, 1'b1, 32'h0000_0042);
        tick();
        clear_inputs();
        check("wrap_instret", o_instret, 64'd0);

        // Random traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            m_if.m_valid      = 1'($urandom_range(0, 1));
            m_if.rd_we        = 1'($urandom_range(0, 3) != 0);
            m_if.rd_idx       = reg_index_t'($urandom_range(0, 31));
            m_if.rd_src       = rd_src_e'($urandom_range(0, 3));
            m_if.alu_result   = $urandom;
            m_if.next_seq_pc  = $urandom;
            m_if.csr_rdata    = $urandom;
            m_if.mem_size     = mem_size_e'($urandom_range(0, 3));
            m_if.mem_unsigned = 1'($urandom_range(0, 1));
            m_if.addr_lo      = 2'($urandom_range(0, 3));
            m_if.ld_rvalid    = ($urandom_range(0, 2) == 0);
            m_if.ld_rdata     = $urandom;
            tick();
        end
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/letc_core_stage_w.md
LETC_CORE_STAGE_W -- requirements
Module: letc_core_stage_w

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port i_m_valid, input, 1 bit: upstream (M stage) packet valid.
REQ-004 SHALL have port o_m_ready, output, 1 bit: this stage accepts a packet this cycle.
REQ-005 SHALL have port i_m_rd_we, input, 1 bit: instruction writes rd.
REQ-006 SHALL have port i_m_rd_idx, input, reg_index_t (5 bits): destination register.
REQ-007 SHALL have port i_m_rd_src, input, rd_src_e (2 bits): source of rd data.
REQ-008 SHALL have ports i_m_alu_result, i_m_next_seq_pc and i_m_csr_rdata, each input, word_t (32 bits): candidate rd values.
REQ-009 SHALL have port i_m_mem_size, input, mem_size_e (2 bits): load width.
REQ-010 SHALL have port i_m_mem_unsigned, input, 1 bit: zero-extend rather than sign-extend the load.
REQ-011 SHALL have port i_m_addr_lo, input, 2 bits: load address bits [1:0].
REQ-012 SHALL have port i_ld_rvalid, input, 1 bit: load response valid, single-cycle pulse.
REQ-013 SHALL have port i_ld_rdata, input, word_t: aligned load response word.
REQ-014 SHALL have port o_rf_we, output, 1 bit: register-file write strobe.
REQ-015 SHALL have port o_rf_idx, output, reg_index_t: register-file write index.
REQ-016 SHALL have port o_rf_wdata, output, word_t: register-file write data.
REQ-017 SHALL have port o_retire, output, 1 bit: one-cycle pulse per retired instruction.
REQ-018 SHALL have port o_instret, output, 64 bits: count of retired instructions.

Function
REQ-019 SHALL implement an FSM with states W_IDLE and W_WAIT_LOAD; o_m_ready SHALL be 1 in W_IDLE and 0 in W_WAIT_LOAD.
REQ-020 SHALL accept a packet when i_m_valid && o_m_ready, and SHALL ignore upstream inputs at all other times.
REQ-021 On accepting a packet with rd_src != RD_FROM_MEM_LOAD, the stage SHALL retire it in the next cycle (latency 1, throughput 1/cycle) and SHALL stay in W_IDLE.
REQ-022 On accepting a packet with rd_src == RD_FROM_MEM_LOAD, the stage SHALL latch rd_we, rd_idx, mem_size, mem_unsigned and addr_lo, and SHALL go to W_WAIT_LOAD.
REQ-023 In W_WAIT_LOAD, on i_ld_rvalid the stage SHALL format i_ld_rdata, retire the load the next cycle, and return to W_IDLE.
REQ-024 In W_WAIT_LOAD, the stage SHALL wait indefinitely while i_ld_rvalid is 0.
REQ-025 SHALL ignore i_ld_rvalid while in W_IDLE, including in the cycle a load is accepted.
REQ-026 Load formatting for SIZE_BYTE SHALL take byte addr_lo.
REQ-027 Load formatting for SIZE_HALFWORD SHALL take the halfword at addr_lo[1], ignoring addr_lo[0].
REQ-028 Load formatting for SIZE_WORD, or encoding 2'b11, SHALL take the whole word and ignore addr_lo.
REQ-029 Sub-word load results SHALL be sign-extended unless mem_unsigned is 1, in which case they SHALL be zero-extended.
REQ-030 Retire SHALL mean registered outputs for one cycle: o_retire=1, o_rf_idx=rd_idx, o_rf_wdata=selected value, o_rf_we = rd_we && (rd_idx != 0).
REQ-031 When not retiring, o_retire and o_rf_we SHALL be 0, and o_rf_idx and o_rf_wdata SHALL hold their last values.
REQ-032 A packet with rd_we=0 SHALL still retire; a load with rd_we=0 SHALL still wait for i_ld_rvalid.
REQ-033 o_instret SHALL increment by 1 in the same cycle o_retire is asserted, and SHALL wrap from 2^64-1 to 0.

Reset
REQ-034 While i_rst=1: FSM SHALL be W_IDLE; o_rf_we, o_retire, o_rf_idx, o_rf_wdata and o_instret SHALL be 0; o_m_ready SHALL be 1.
REQ-035 Reset asserted during W_WAIT_LOAD SHALL discard the pending load, with no write after deassertion, even if i_ld_rvalid arrives.

Structure
REQ-036 mem_size_e (SIZE_BYTE=2'b00, SIZE_HALFWORD=2'b01, SIZE_WORD=2'b10) SHALL be added to core_pkg.
REQ-037 reg_index_t, rd_src_e and word_t SHALL be taken from core_pkg.
REQ-038 Load formatting SHALL be a combinational sub-module letc_core_load_fmt (inputs: rdata, size, unsigned, addr_lo; output: word_t).

Verification
REQ-039 SHALL cover back-to-back ALU packets: 3 cycles with rd_src=ALU_RESULT, rd_idx=5/6/7, alu=0x11/0x22/0x33 -> 3 consecutive o_rf_we pulses with matching data; o_instret=3.
REQ-040 SHALL cover a signed byte load: size=BYTE, addr_lo=2, unsigned=0, rvalid 4 cycles later with rdata=0x12_80_34_56 -> o_m_ready low 5 cycles, then o_rf_wdata=0xFFFFFF80.
REQ-041 SHALL cover an unsigned halfword load: addr_lo=3, rdata=0xBEEF1234 -> 0x0000BEEF.
REQ-042 SHALL cover a write to x0: rd_idx=0, rd_we=1 -> o_retire=1, o_rf_we=0, o_instret increments.
REQ-043 SHALL cover reset in W_WAIT_LOAD: assert i_rst, then pulse i_ld_rvalid -> no o_rf_we or o_retire pulse; o_instret=0.
REQ-044 SHALL cover counter wrap: force o_instret to 2^64-1, retire one packet -> o_instret=0.
